// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W : width of one adder slice
//   state_e  : control FSM states
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit ripple-carry adder slice.
// Ports:
//   x, y   : nibble operands
//   c_in   : carry into bit 0
//   s      : nibble sum
//   c_out  : carry out of bit 3
//   v      : signed overflow of the slice (carry into bit 3 XOR carry out of bit 3)
module nibble_add4
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out,
  output logic                v
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
  end

  assign c_out = c[NIBBLE_W];
  assign v     = c[NIBBLE_W-1] ^ c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: accepts W-bit operands on a valid/ready handshake, adds one
// nibble per clock through a single time-multiplexed nibble_add4, and presents
// the result on a second valid/ready handshake.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b, c_in)
//   a, b, c_in          : operands and carry into nibble 0
//   out_valid, out_ready: result handshake
//   sum, c_out, v       : A+B+c_in mod 2^W, unsigned carry out, signed overflow
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         v
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e state_q, state_d;

  logic [IdxW-1:0]     idx_q;
  logic [W-1:0]        a_q, b_q;
  logic                carry_q;
  logic [W-1:0]        sum_q, sum_d;
  logic                c_out_q, v_q;

  logic [NIBBLE_W-1:0] x_nib, y_nib, s_nib;
  logic                nib_c, nib_v;
  logic                accept;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (idx_q == LastIdx) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode registered state only; in_ready is also held low
  // while reset is asserted.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
  end

  assign accept = in_valid && in_ready;

  // Select the active nibble of each operand
  always_comb begin
    x_nib = '0;
    y_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        x_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        y_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_add4 u_nibble_add4 (
    .x     (x_nib),
    .y     (y_nib),
    .c_in  (carry_q),
    .s     (s_nib),
    .c_out (nib_c),
    .v     (nib_v)
  );

  // Merge the fresh nibble sum into its slot of the result
  always_comb begin
    sum_d = sum_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        sum_d[i*NIBBLE_W +: NIBBLE_W] = s_nib;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= nib_c;
          if (idx_q == LastIdx) begin
            // Only the top nibble's flags describe the full-width result
            c_out_q <= nib_c;
            v_q     <= nib_v;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign v     = v_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4): directed vectors push
// hand-computed results into a queue; a monitor pops and compares on each
// output handshake.
module tb_nibble_serial_adder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         v;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected {sum, c_out, v}
  logic [W+1:0] exp_q[$];

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .v         (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) begin
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      pass_cnt++;
    end
  endtask

  // Monitor: compare at every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {14'd0, sum, c_out, v}, 32'hDEAD_BEEF);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("result", {14'd0, sum, c_out, v}, {14'd0, e});
      end
    end
  end

  // Drive one operand set; returns after the acceptance edge (+#1)
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input bit push, input logic [W+1:0] expv);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    a = av; b = bv; c_in = cv; in_valid = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  typedef struct packed {
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         cv;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc;
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'h0004, 16'h0001, 1'b0, 16'h0005, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h0F0F, 16'h00F0, 1'b1, 16'h1000, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    check("out_valid_in_reset", {31'd0, out_valid}, 32'd0);
    check("sum_in_reset", {16'd0, sum}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // Directed vectors with out_ready held high
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].av, vecs[i].bv, vecs[i].cv, 1'b1, {vecs[i].s, vecs[i].co, vecs[i].ov});
      wait_valid(cyc);
      check("latency", cyc, N);
      @(posedge clk); #1;
    end

    // Back-pressure with ignored in_valid pulses
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b1, {16'h2345, 1'b0, 1'b0});
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    check("bp_latency", cyc, N - 1);
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_sum_stable", {16'd0, sum}, 32'h0000_2345);
    end
    a = '0; b = '0; c_in = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_handshake", {31'd0, in_ready}, 32'd1);
    send(16'h0004, 16'h0001, 1'b0, 1'b1, {16'h0005, 1'b0, 1'b0});
    wait_valid(cyc);
    check("post_bp_latency", cyc, N);
    @(posedge clk); #1;

    // Reset during the second RUN cycle
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_sum", {16'd0, sum}, 32'd0);
    check("abort_c_out", {31'd0, c_out}, 32'd0);
    check("abort_v", {31'd0, v}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_in_ready_release", {31'd0, in_ready}, 32'd1);
    repeat (N + 2) @(posedge clk);
    #1;
    check("abort_no_out_valid", {31'd0, out_valid}, 32'd0);
    send(16'h0004, 16'h0001, 1'b0, 1'b1, {16'h0005, 1'b0, 1'b0});
    wait_valid(cyc);
    check("fresh_latency", cyc, N);
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
